// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin controller for a 4:1 data multiplexer. Four producers (a..d)
//   share one registered output channel. A grant lasts for a burst. The burst
//   ends on a beat flagged with `last`, on reaching MAX_BURST beats, or when the
//   granted requester withdraws its request.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req[3:0]              per-requester request (bit0=a .. bit3=d)
//   last[3:0]             per-requester end-of-burst flag, qualified by ack
//   data_a..data_d        requester data, DW bits each
//   gnt[3:0]              registered one-hot grant, zero when idle
//   sel[1:0]              registered mux select (index of the granted port)
//   ack[3:0]              combinational beat-accepted strobe
//   out_data, out_valid   registered output beat
//   out_ready             consumer accepts the beat this cycle
//   dbg_state_o           FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr_o             round-robin priority pointer
//
// Handshake: a beat moves from requester to output register in any cycle where
// load is high (ack pulses to the granted requester). The output beat is
// consumed in any cycle where out_valid && out_ready. out_data is stable while
// out_valid && !out_ready.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int DW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [3:0]    last,
  input  logic [DW-1:0] data_a,
  input  logic [DW-1:0] data_b,
  input  logic [DW-1:0] data_c,
  input  logic [DW-1:0] data_d,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [3:0]    ack,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          dbg_state_o,
  output logic [1:0]    dbg_ptr_o
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [3:0]    cnt_q;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;

  logic [DW-1:0] sel_data;
  logic          load;
  logic [3:0]    beat_inc;
  logic          grant_end;
  logic [1:0]    pick_idx;

  // Data mux driven by the registered select.
  always_comb begin
    sel_data = data_a;
    case (sel_q)
      2'd0: sel_data = data_a;
      2'd1: sel_data = data_b;
      2'd2: sel_data = data_c;
      2'd3: sel_data = data_d;
      default: sel_data = data_a;
    endcase
  end

  // A beat is taken only while granted, requested, and the output slot is free
  // or being emptied this same cycle.
  assign load     = (state_q == S_GRANT) && req[sel_q] && (!out_valid_q || out_ready);
  assign ack      = load ? gnt_q : 4'b0000;
  assign beat_inc = cnt_q + 4'd1;

  // Withdrawal implies no load, so !req[sel_q] covers case (c) on its own.
  assign grant_end = (load && (last[sel_q] || (beat_inc == 4'(MAX_BURST))))
                   || !req[sel_q];

  // Round-robin pick: scan offsets 3..0 so the smallest offset from ptr wins.
  always_comb begin
    pick_idx = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) pick_idx = ptr_q + 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= 4'd0;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (load) begin
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q   <= 4'b0001 << pick_idx;
            sel_q   <= pick_idx;
            cnt_q   <= 4'd0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (load) cnt_q <= beat_inc;
          if (grant_end) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            ptr_q   <= sel_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign sel         = sel_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int DW        = 4;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    req = '0;
  logic [3:0]    last = '0;
  logic [DW-1:0] tb_data [4];
  logic          out_ready = 1'b0;

  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [3:0]    ack;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          dbg_state;
  logic [1:0]    dbg_ptr;

  mux4_rr_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .last        (last),
    .data_a      (tb_data[0]),
    .data_b      (tb_data[1]),
    .data_c      (tb_data[2]),
    .data_d      (tb_data[3]),
    .gnt         (gnt),
    .sel         (sel),
    .ack         (ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // owner = granted port or -1; next_first = port with top priority next idle.
  int            m_owner;
  int            m_next_first;
  int            m_sel;
  int            m_beats;
  bit            m_full;
  logic [DW-1:0] m_held;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_owner = -1;
    m_next_first = 0;
    m_sel = 0;
    m_beats = 0;
    m_full = 0;
    m_held = '0;
    exp_q.delete();
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) tb_data[i] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  // One clock cycle: compare outputs at the falling edge against the model,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic step();
    logic [3:0]    e_gnt;
    logic [3:0]    e_ack;
    logic [DW-1:0] e_beat;
    bit            took;
    @(negedge clk);
    took  = (m_owner >= 0) && req[m_owner] && (!m_full || out_ready);
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_ack = took ? e_gnt : 4'b0000;

    n_vec++;
    if (gnt !== e_gnt) begin n_err++; $display("FAIL gnt: got %b want %b @%0t", gnt, e_gnt, $time); end
    n_vec++;
    if (sel !== 2'(m_sel)) begin n_err++; $display("FAIL sel: got %0d want %0d @%0t", sel, m_sel, $time); end
    n_vec++;
    if (ack !== e_ack) begin n_err++; $display("FAIL ack: got %b want %b @%0t", ack, e_ack, $time); end
    n_vec++;
    if (out_valid !== m_full) begin n_err++; $display("FAIL out_valid: got %b want %b @%0t", out_valid, m_full, $time); end
    if (m_full) begin
      n_vec++;
      if (out_data !== m_held) begin n_err++; $display("FAIL out_data: got %h want %h @%0t", out_data, m_held, $time); end
    end
    n_vec++;
    if (dbg_state !== (m_owner >= 0)) begin n_err++; $display("FAIL state: got %b want %b @%0t", dbg_state, (m_owner >= 0), $time); end
    n_vec++;
    if (dbg_ptr !== 2'(m_next_first)) begin n_err++; $display("FAIL ptr: got %0d want %0d @%0t", dbg_ptr, m_next_first, $time); end

    // scoreboard: every consumed beat must be the oldest accepted beat
    if (out_valid === 1'b1 && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL sb_empty: got beat %h want none @%0t", out_data, $time);
      end else begin
        e_beat = exp_q.pop_front();
        if (out_data !== e_beat) begin n_err++; $display("FAIL sb_beat: got %h want %h @%0t", out_data, e_beat, $time); end
      end
    end

    // advance model
    if (took) begin
      m_held = tb_data[m_owner];
      m_full = 1;
      m_beats = m_beats + 1;
      exp_q.push_back(tb_data[m_owner]);
    end else if (out_ready) begin
      m_full = 0;
    end
    if (m_owner < 0) begin
      if (req != 4'b0000) begin
        for (int k = 3; k >= 0; k--) begin
          if (req[(m_next_first + k) % 4]) m_owner = (m_next_first + k) % 4;
        end
        m_sel = m_owner;
        m_beats = 0;
      end
    end else if ((took && (last[m_owner] || m_beats == MAX_BURST)) || !req[m_owner]) begin
      m_next_first = (m_owner + 1) % 4;
      m_owner = -1;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; last = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || ack !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs: got gnt=%b sel=%0d ov=%b od=%h ack=%b want all zero", gnt, sel, out_valid, out_data, ack);
    end
    n_vec++;
    if (dbg_state !== 1'b0 || dbg_ptr !== 2'd0) begin
      n_err++; $display("FAIL reset_state: got state=%b ptr=%0d want 0/0", dbg_state, dbg_ptr);
    end
    do_reset();
  endtask

  task automatic test_single();
    req = 4'b0010; last = 4'b0010; out_ready = 1'b1;
    randomize_data();
    tb_data[1] = 4'h5;
    step();                       // IDLE, arbitration
    n_vec++;
    if (gnt !== 4'b0010 || sel !== 2'd1 || ack !== 4'b0010) begin
      n_err++; $display("FAIL single_grant: got gnt=%b sel=%0d ack=%b want 0010/1/0010", gnt, sel, ack);
    end
    step();                       // beat accepted
    req = 4'b0000;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 4'h5 || gnt !== 4'b0000) begin
      n_err++; $display("FAIL single_out: got ov=%b od=%h gnt=%b want 1/5/0000", out_valid, out_data, gnt);
    end
    repeat (3) step();
  endtask

  task automatic test_round_robin();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      randomize_data();
      step();
    end
    req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_burst_limit();
    do_reset();
    req = 4'b0101; last = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      randomize_data();
      step();
    end
    req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    int guard;
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    guard = 0;
    while (!(m_owner == 1 && m_beats == 1) && guard < 20) begin
      randomize_data();
      step();
      guard++;
    end
    n_vec++;
    if (guard >= 20) begin n_err++; $display("FAIL bp_timeout: got no first beat to b want one within 20 cycles"); end
    out_ready = 1'b0;
    repeat (3) begin
      randomize_data();
      step();
    end
    out_ready = 1'b1;
    repeat (5) begin
      randomize_data();
      step();
    end
    req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_withdrawal();
    int guard;
    do_reset();
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    guard = 0;
    while (!(m_owner == 2 && m_beats == 2) && guard < 20) begin
      randomize_data();
      step();
      guard++;
    end
    n_vec++;
    if (guard >= 20) begin n_err++; $display("FAIL wd_timeout: got fewer than 2 beats to c want 2 within 20 cycles"); end
    req = 4'b0000;
    step();                       // withdrawal ends the grant
    req = 4'b1001;
    step();                       // IDLE, arbitration from d
    n_vec++;
    if (gnt !== 4'b1000) begin n_err++; $display("FAIL wd_next: got gnt=%b want 1000", gnt); end
    last = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      step();
    end
    req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    int guard;
    req = 4'b0100; last = 4'b0000; out_ready = 1'b0;
    guard = 0;
    while (!m_full && guard < 20) begin
      randomize_data();
      step();
      guard++;
    end
    n_vec++;
    if (guard >= 20) begin n_err++; $display("FAIL ar_timeout: got out_valid=0 want 1 within 20 cycles"); end
    rst_n = 1'b0;                 // mid-cycle, no clock edge involved
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd0 || out_data !== '0 || ack !== 4'b0000) begin
      n_err++; $display("FAIL async_reset: got ov=%b gnt=%b sel=%0d od=%h ack=%b want all zero", out_valid, gnt, sel, out_data, ack);
    end
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    req = 4'b1000; last = 4'b1000; out_ready = 1'b1;
    step();
    n_vec++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin n_err++; $display("FAIL ar_regrant: got gnt=%b sel=%0d want 1000/3", gnt, sel); end
    req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_data();
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      last = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req = 4'b0000; out_ready = 1'b1;
    repeat (4) step();
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d beats left want 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tb_data[i] = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_withdrawal();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin controller for a 4-requester, 4:1 data multiplexer.
- Shares one output channel between requesters a/b/c/d. Each grant is held for a burst, ended by `last`, a beat limit, or request withdrawal.
- Drives the mux select and registers the selected data into a valid/ready output stage.
- Sits between four producer ports and a single downstream consumer.

Parameters:
- DW, 4, data width of each requester and of the output.
- MAX_BURST, 4, maximum beats per grant before forced rotation (legal range 1..15).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d. A requester holds it high while it has data.
- last  input  4  per-requester end-of-burst flag, qualified by that requester's ack.
- data_a, data_b, data_c, data_d  input  DW each  requester data.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  registered mux select, encodes gnt (a=0, b=1, c=2, d=3).
- ack  output  4  combinational beat-accepted strobe to the granted requester.
- out_data  output  DW  registered selected data.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- Reset: gnt=0, sel=0, out_valid=0, out_data=0, state=IDLE, priority pointer ptr=0 (a highest), beat count=0.
- Reset is asynchronous: asserting rst_n mid-burst clears everything immediately. Any beat held in the output register is dropped.
- Output stage:
  - load = (state==GRANT) && req[sel] && (!out_valid || out_ready).
  - ack = gnt when load=1, else 0.
  - On load: out_data <= selected data, out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - out_data holds its value while out_valid && !out_ready.
  - Throughput is one beat per cycle when out_ready is held high.
- IDLE state:
  - gnt=0.
  - If any req is set, scan from ptr upward modulo 4 and pick the first set bit.
  - Next cycle: gnt = that one-hot, sel = its index, beat count=0, state=GRANT.
  - Arbitration costs exactly one cycle. No beat loads in IDLE.
- GRANT state:
  - gnt and sel are stable for the whole burst. Only the granted requester can receive ack.
  - Each load increments the beat count.
  - The grant ends, returning to IDLE next cycle, when any of the following occurs:
    - (a) load with last[sel]=1;
    - (b) load that makes beat count == MAX_BURST;
    - (c) req[sel]=0 with no load (withdrawal; no beat is transferred).
  - On end: ptr <= sel+1 mod 4, gnt <= 0.
  - A requester that drops req and reasserts it in the same cycle is not distinguished from one holding req.
- Latency:
  - Request rises in cycle N (state IDLE, output empty) → gnt at N+1 → first ack in N+1 → out_valid at N+2.
  - Minimum gap between bursts is one IDLE cycle. Bursts never overlap.
- Fairness: a continuously requesting port waits at most 3 bursts of others.
- Requests from non-granted ports during GRANT are ignored until the next IDLE.
- Backpressure:
  - When out_ready=0 and out_valid=1, load=0. ack stays low and the burst stalls with no timeout.
  - Withdrawal during a stall ends the grant per (c).
- Simultaneous events:
  - last and MAX_BURST on the same beat count as a single end.
  - Withdrawal in the same cycle as the output becoming free: load=0, so the grant ends.
- Beat-count width: 4 bits; MAX_BURST=1 gives single-beat grants.

Test Plan:
- Reset/single requester: rst_n low then high; req=4'b0010, data_b=4'h5, last[1]=1, out_ready=1. Expect gnt=4'b0010 and sel=1 one cycle later, ack[1] for one cycle, out_valid=1 with out_data=4'h5 the next cycle, then gnt=0.
- Round-robin: req=4'b1111 held, last=4'b1111, out_ready=1. Expect grant order a,b,c,d,a with one IDLE cycle between grants and out_data sequencing data_a..data_d.
- Burst limit: req=4'b0101, last=0, MAX_BURST=4. Expect exactly 4 acks to a, IDLE, then 4 acks to c, then a again.
- Backpressure: b granted, out_ready=0 for 3 cycles after the first beat. Expect out_data=data_b held stable and ack=0 during the stall. Beats resume one per cycle once out_ready=1.
- Withdrawal: c granted, req[2] dropped after 2 beats with last=0. Expect gnt=0 next cycle and ptr pointing at d. A following req=4'b1001 grants d before a.
- Async reset mid-burst: rst_n low while out_valid=1. Expect out_valid, gnt, sel, out_data all 0 immediately, without waiting for a clock edge. After release, req=4'b1000 with ptr=0 grants d normally.
